// File: rtl/bus_pkg.sv
// Shared types and constants for the 8086-style bus cycle generator.
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
//   bus_state_t             : one-hot bus cycle state (IDLE, T1, T2, T3, TW, T4)
//   bus_req_t               : latched core request (write, iom, addr, wdata)
//   RDATA_ERR               : read data returned when a cycle times out
package bus_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 8;

  // One-hot codes, kept as plain constants so older code can compare against them.
  localparam logic [5:0] ST_IDLE = 6'b000001;
  localparam logic [5:0] ST_T1   = 6'b000010;
  localparam logic [5:0] ST_T2   = 6'b000100;
  localparam logic [5:0] ST_T3   = 6'b001000;
  localparam logic [5:0] ST_TW   = 6'b010000;
  localparam logic [5:0] ST_T4   = 6'b100000;

  typedef enum logic [5:0] {
    IDLE = ST_IDLE,
    T1   = ST_T1,
    T2   = ST_T2,
    T3   = ST_T3,
    TW   = ST_TW,
    T4   = ST_T4
  } bus_state_t;

  typedef struct packed {
    logic                  write;
    logic                  iom;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } bus_req_t;

  localparam logic [DATA_W_DEF-1:0] RDATA_ERR = '1;

endpackage

// File: rtl/bus_cycle_gen_if.sv
// Core-side request/response handshake plus the device-side bus pins.
//   slave  : view of the bus cycle generator (takes requests, drives the bus)
//   master : view of the core/device environment (issues requests, drives Data/READY)
// Signals: req_valid/req_ready/req_write/req_iom/req_addr/req_wdata,
//          rsp_valid/rsp_rdata/rsp_err, ALE/RD/WR/IOM/Address/WrData, Data/READY.
interface bus_cycle_gen_if
  import bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_iom;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              ALE;
  logic              RD;
  logic              WR;
  logic              IOM;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WrData;
  logic [DATA_W-1:0] Data;
  logic              READY;

  modport slave (
    input  req_valid, req_write, req_iom, req_addr, req_wdata, Data, READY,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output ALE, RD, WR, IOM, Address, WrData
  );

  modport master (
    output req_valid, req_write, req_iom, req_addr, req_wdata, Data, READY,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  ALE, RD, WR, IOM, Address, WrData
  );

endinterface

// File: rtl/bus_wait_timer.sv
// Wait-state counter for the TW phase.
//   CLK      : clock
//   RESET    : asynchronous active-low reset
//   clear    : return count to zero (wins over count_en)
//   count_en : advance count by one
//   expired  : count has reached WAIT_MAX
module bus_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (count_en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == CNT_W'(WAIT_MAX));

endmodule

// File: rtl/bus_cycle_gen.sv
// 8086-style bus cycle generator: runs T1-T2-T3-[TW]-T4 for single-byte
// read/write requests and returns a one-cycle response.
//   CLK   : bus clock, all state on rising edge
//   RESET : asynchronous active-low reset
//   bus   : slave modport of bus_cycle_gen_if (request/response handshake,
//           ALE/RD/WR/IOM/Address/WrData outputs, Data/READY inputs)
module bus_cycle_gen
  import bus_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WAIT_MAX = 15
) (
  input  logic            CLK,
  input  logic            RESET,
  bus_cycle_gen_if.slave  bus
);

  bus_state_t        state_reg;
  bus_state_t        state_next;
  logic              write_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              accept;
  logic              wait_en;
  logic              wait_clear;
  logic              wait_expired;
  logic              timeout;
  logic              strobe_next;
  logic              enter_t4;

  assign bus.req_ready = (state_reg == IDLE) || (state_reg == T4);
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    state_next = state_reg;
    wait_en    = 1'b0;
    timeout    = 1'b0;
    case (state_reg)
      IDLE: if (accept) state_next = T1;
      T1:   state_next = T2;
      T2:   state_next = T3;
      T3: begin
        if (bus.READY) begin
          state_next = T4;
        end else begin
          state_next = TW;
          wait_en    = 1'b1;   // first TW cycle sees count 1
        end
      end
      TW: begin
        // READY has priority over the timeout in the last permitted TW.
        if (bus.READY) begin
          state_next = T4;
        end else if (wait_expired) begin
          state_next = T4;
          timeout    = 1'b1;
        end else begin
          wait_en = 1'b1;
        end
      end
      T4:      state_next = accept ? T1 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_t4    = (state_next == T4);
  assign wait_clear  = enter_t4;
  assign strobe_next = (state_next == T2) || (state_next == T3) || (state_next == TW);

  bus_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .CLK      (CLK),
    .RESET    (RESET),
    .clear    (wait_clear),
    .count_en (wait_en),
    .expired  (wait_expired)
  );

  // Bus pins are decoded from the next state so every output is a flop.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg     <= IDLE;
      write_reg     <= 1'b0;
      wdata_reg     <= '0;
      bus.ALE       <= 1'b0;
      bus.RD        <= 1'b1;
      bus.WR        <= 1'b1;
      bus.IOM       <= 1'b0;
      bus.Address   <= '0;
      bus.WrData    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bus.ALE       <= (state_next == T1);
      bus.RD        <= ~(strobe_next & ~write_reg);
      bus.WR        <= ~(strobe_next & write_reg);
      bus.rsp_valid <= enter_t4;

      if (accept) begin
        write_reg   <= bus.req_write;
        wdata_reg   <= bus.req_wdata;
        bus.Address <= bus.req_addr;
        bus.IOM     <= bus.req_iom;
      end

      if ((state_next == T2) && write_reg) begin
        bus.WrData <= wdata_reg;
      end

      // Read data is taken on the edge that leaves T3/TW; writes leave rsp_rdata alone.
      if (enter_t4) begin
        bus.rsp_err <= timeout;
        if (!write_reg) begin
          bus.rsp_rdata <= timeout ? {DATA_W{1'b1}} : bus.Data;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_cycle_gen.sv
// Testbench for bus_cycle_gen: directed transactions plus a per-cycle
// timeline model of the expected bus waveform.
module tb_bus_cycle_gen;
  import bus_pkg::*;

  localparam int AW       = 20;
  localparam int DW       = 8;
  localparam int WAIT_MAX = 15;
  localparam int NCYC     = 1024;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  bus_cycle_gen_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  bus_cycle_gen #(.ADDR_W(AW), .DATA_W(DW), .WAIT_MAX(WAIT_MAX)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ready_low_cur = 0;   // READY-low cycles from T3 for the request being offered

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected timeline indexed by cycle number.
  bit              e_ale  [NCYC];
  bit              e_rd   [NCYC];
  bit              e_wr   [NCYC];
  bit              e_rsp  [NCYC];
  bit              e_err  [NCYC];
  bit              e_av   [NCYC];
  bit              e_wdv  [NCYC];
  bit              e_iom  [NCYC];
  logic [AW-1:0]   e_addr [NCYC];
  logic [DW-1:0]   e_wd   [NCYC];
  logic [DW-1:0]   e_rdat [NCYC];
  int              rsp_cyc = 0;
  logic [DW-1:0]   last_rdata = '0;

  task automatic clear_slot(input int i);
    e_ale[i] = 0; e_rd[i] = 1; e_wr[i] = 1; e_rsp[i] = 0; e_err[i] = 0;
    e_av[i] = 0; e_wdv[i] = 0; e_iom[i] = 0; e_addr[i] = '0; e_wd[i] = '0; e_rdat[i] = '0;
  endtask

  // Model: a request offered while the generator is free starts T1 next cycle,
  // strobes cover T2..T3 plus min(ready_low, WAIT_MAX) wait cycles, response follows.
  task automatic schedule(input bus_req_t r, input int rl, input logic [DW-1:0] dev);
    int  w;
    bit  e;
    w = (rl > WAIT_MAX) ? WAIT_MAX : rl;
    e = (rl > WAIT_MAX);
    e_ale[cyc+1] = 1;
    for (int k = 1; k <= 4 + w; k++) begin
      e_av[cyc+k] = 1; e_addr[cyc+k] = r.addr; e_iom[cyc+k] = r.iom;
    end
    for (int k = 2; k <= 3 + w; k++) begin
      if (r.write) e_wr[cyc+k] = 0; else e_rd[cyc+k] = 0;
    end
    if (r.write) begin
      for (int k = 2; k <= 4 + w; k++) begin
        e_wdv[cyc+k] = 1; e_wd[cyc+k] = r.wdata;
      end
    end else begin
      last_rdata = e ? RDATA_ERR : dev;
    end
    rsp_cyc = cyc + 4 + w;
    e_rsp[rsp_cyc]  = 1;
    e_err[rsp_cyc]  = e;
    e_rdat[rsp_cyc] = last_rdata;
  endtask

  // Compare process: one evaluation per cycle, 1 ns after the falling edge.
  initial begin
    bus_req_t r;
    for (int i = 0; i < NCYC; i++) clear_slot(i);
    forever begin
      @(negedge CLK);
      #1;
      cyc++;
      if (!RESET) begin
        rsp_cyc    = 0;
        last_rdata = '0;
        for (int i = cyc; i < cyc + 64 && i < NCYC; i++) clear_slot(i);
      end else if (cyc < NCYC - 64) begin
        chk("req_ready", 32'(bus.req_ready), 32'(cyc >= rsp_cyc));
        chk("ALE",       32'(bus.ALE),       32'(e_ale[cyc]));
        chk("RD",        32'(bus.RD),        32'(e_rd[cyc]));
        chk("WR",        32'(bus.WR),        32'(e_wr[cyc]));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp[cyc]));
        if (e_av[cyc]) begin
          chk("Address", 32'(bus.Address), 32'(e_addr[cyc]));
          chk("IOM",     32'(bus.IOM),     32'(e_iom[cyc]));
        end
        if (e_wdv[cyc]) chk("WrData", 32'(bus.WrData), 32'(e_wd[cyc]));
        if (e_rsp[cyc]) begin
          chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e_rdat[cyc]));
          chk("rsp_err",   32'(bus.rsp_err),   32'(e_err[cyc]));
        end
        if (bus.req_valid && cyc >= rsp_cyc) begin
          r = '{write: bus.req_write, iom: bus.req_iom, addr: bus.req_addr, wdata: bus.req_wdata};
          schedule(r, ready_low_cur, bus.Data);
        end
      end else begin
        chk("cycle_budget", 32'(cyc), 32'(NCYC - 64));
        $fatal(1, "cycle budget exhausted");
      end
    end
  end

  // One request; READY is low from T3 for rl cycles (and, harmlessly, in T1/T2).
  task automatic run_txn(input string tag, input bit wr, input bit iom,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [DW-1:0] dev, input int rl, input int exp_lat,
                         input logic [DW-1:0] exp_rdata, input bit exp_err);
    int lat;
    bit ok;
    lat = 0;
    ok  = 0;
    @(negedge CLK);
    bus.req_valid = 1; bus.req_write = wr; bus.req_iom = iom;
    bus.req_addr = addr; bus.req_wdata = wd; bus.Data = dev;
    bus.READY = 0; ready_low_cur = rl;
    #1;
    for (int t = 0; t < 20 && !bus.req_ready; t++) begin
      @(negedge CLK);
      #1;
    end
    chk({tag, "_accept"}, 32'(bus.req_ready), 32'(1));
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      bus.req_valid = 0;
      bus.req_write = ~wr; bus.req_iom = ~iom; bus.req_addr = ~addr; bus.req_wdata = ~wd;
      bus.READY = (k > 2 + rl);
      #1;
      if (bus.rsp_valid) begin
        lat = k;
        ok  = 1;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (ok) begin
      chk({tag, "_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rdata));
      chk({tag, "_err"},   32'(bus.rsp_err),   32'(exp_err));
    end
    $display("txn %s write=%0d addr=%05h ready_low=%0d latency=%0d rdata=%02h err=%0d",
             tag, wr, addr, rl, lat, bus.rsp_rdata, bus.rsp_err);
    bus.READY = 1;
  endtask

  initial begin
    int rsp_k [3];
    int nrsp;
    int acc;
    int ale_cnt;

    bus.req_valid = 0; bus.req_write = 0; bus.req_iom = 0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.Data = '0; bus.READY = 1;

    // Reset values
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_ALE",       32'(bus.ALE),       32'(0));
    chk("rst_RD",        32'(bus.RD),        32'(1));
    chk("rst_WR",        32'(bus.WR),        32'(1));
    chk("rst_IOM",       32'(bus.IOM),       32'(0));
    chk("rst_Address",   32'(bus.Address),   32'(0));
    chk("rst_WrData",    32'(bus.WrData),    32'(0));
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'(0));
    chk("rst_rsp_err",   32'(bus.rsp_err),   32'(0));
    chk("rst_req_ready", 32'(bus.req_ready), 32'(1));
    $display("txn reset checked");
    @(negedge CLK);
    RESET = 1;
    repeat (2) @(negedge CLK);

    run_txn("read0",    0, 1, 20'h00010, 8'h00, 8'h5A, 0,  4,  8'h5A, 0);
    run_txn("write0",   1, 0, 20'h00020, 8'hC3, 8'h00, 0,  4,  8'h5A, 0);
    run_txn("read_w3",  0, 0, 20'h00031, 8'h00, 8'h3C, 3,  7,  8'h3C, 0);
    run_txn("read_w15", 0, 1, 20'hABCDE, 8'h00, 8'h96, 15, 19, 8'h96, 0);
    run_txn("read_to",  0, 0, 20'h00040, 8'h00, 8'h11, 20, 19, 8'hFF, 1);
    run_txn("write_to", 1, 1, 20'h00050, 8'h77, 8'h00, 16, 19, 8'hFF, 1);

    // Back-to-back reads with req_valid held high
    @(negedge CLK);
    bus.req_valid = 1; bus.req_write = 0; bus.req_iom = 0;
    bus.req_addr = 20'h00100; bus.Data = 8'hA5; bus.READY = 1; ready_low_cur = 0;
    nrsp = 0; acc = 0; ale_cnt = 0;
    for (int k = 0; k < 40 && nrsp < 3; k++) begin
      #1;
      if (bus.rsp_valid) begin
        rsp_k[nrsp] = k;
        nrsp++;
      end
      if (bus.ALE) ale_cnt++;
      if (bus.req_valid && bus.req_ready) acc++;
      @(negedge CLK);
      if (acc == 3) bus.req_valid = 0;
      else bus.req_addr = 20'h00100 + 20'(acc);
    end
    chk("b2b_rsp_count", 32'(nrsp), 32'(3));
    chk("b2b_ale_count", 32'(ale_cnt), 32'(3));
    if (nrsp == 3) begin
      chk("b2b_first_lat", 32'(rsp_k[0]), 32'(4));
      chk("b2b_gap1",      32'(rsp_k[1] - rsp_k[0]), 32'(4));
      chk("b2b_gap2",      32'(rsp_k[2] - rsp_k[1]), 32'(4));
    end
    $display("txn back_to_back responses=%0d ale_pulses=%0d", nrsp, ale_cnt);
    bus.req_valid = 0;
    repeat (2) @(negedge CLK);

    // Reset during T3 of a read
    bus.req_valid = 1; bus.req_write = 0; bus.req_iom = 1;
    bus.req_addr = 20'h00055; bus.Data = 8'hEE; bus.READY = 1; ready_low_cur = 0;
    @(negedge CLK);
    bus.req_valid = 0;
    @(negedge CLK);
    @(posedge CLK);
    #2;
    chk("pre_reset_RD", 32'(bus.RD), 32'(0));
    RESET = 0;
    #1;
    chk("async_rst_RD",        32'(bus.RD),        32'(1));
    chk("async_rst_WR",        32'(bus.WR),        32'(1));
    chk("async_rst_ALE",       32'(bus.ALE),       32'(0));
    chk("async_rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    $display("txn reset_mid_T3 RD=%0d ALE=%0d", bus.RD, bus.ALE);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      #1;
      chk("no_rsp_after_abort", 32'(bus.rsp_valid), 32'(0));
    end
    run_txn("read_after_rst", 0, 0, 20'h00066, 8'h00, 8'h42, 0, 4, 8'h42, 0);

    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_cycle_gen.md
Name: bus_cycle_gen

Overview:
- 8086-style bus cycle generator for the memory/IO device model.
- Accepts single-byte read/write requests from the CPU-side core and runs a T1-T2-T3-[TW]-T4 bus cycle, driving ALE, RD, WR, IOM and Address.
- Captures read data from Data and returns a one-cycle response with optional wait-state timeout.
- Sits directly upstream of the InputOutput device; the core sits above it.

Parameters:
- ADDR_W, 20, address width.
- DATA_W, 8, data width.
- WAIT_MAX, 15, maximum TW cycles before abort (1..255).

Ports:
- CLK  input  1  bus clock; all state on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- req_valid  input  1  core request present.
- req_ready  output  1  request accepted this cycle when req_valid & req_ready.
- req_write  input  1  1 = write, 0 = read.
- req_iom  input  1  1 = IO/memory device space, driven to IOM.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  write byte.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  DATA_W  read byte, valid with rsp_valid.
- rsp_err  output  1  timeout flag, valid with rsp_valid.
- ALE  output  1  address latch enable, high in T1 only.
- RD  output  1  active-low read strobe.
- WR  output  1  active-low write strobe.
- IOM  output  1  space select, held for whole cycle.
- Address  output  ADDR_W  held stable T1..T4.
- WrData  output  DATA_W  write data, valid T2..T4 of write cycles.
- Data  input  DATA_W  read data from device.
- READY  input  1  device ready; tie high for zero-wait devices.

Behaviour:
- Reset values (RESET low, asynchronous): state IDLE, ALE=0, RD=1, WR=1, IOM=0, Address=0, WrData=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
- req_ready is high in IDLE and T4, low otherwise.
- On acceptance, latch write, iom, addr and wdata. Later changes on req_* are ignored until the next acceptance.
- All bus outputs are registered.
- State transitions:
  - IDLE: on accept go to T1.
  - T1: ALE=1, Address/IOM valid; go to T2.
  - T2: ALE=0; RD=0 for reads or WR=0 for writes; go to T3.
  - T3: strobe held. If READY=1 go to T4; else go to TW with counter=1.
  - TW: strobe held. If READY=1 go to T4. Else if counter==WAIT_MAX go to T4 with error. Else counter+1.
  - T4: RD=WR=1; rsp_valid=1. On accept go to T1; otherwise go to IDLE.
- Read capture: Data is sampled on the edge leaving T3/TW with READY=1 into rsp_rdata. This is the cycle in which the device is in its READ state.
- Latency: a zero-wait cycle is T1..T4 = 4 cycles; rsp_valid rises 4 cycles after the accept edge.
- Back-to-back cycles: accepting in T4 gives one transfer per 4 cycles, with no IDLE gap.
- Timeout: rsp_err=1; rsp_rdata=all-ones for reads; writes are reported failed. The counter clears on entry to T4.
- rsp_err=0 on normal completion. rsp_rdata is unchanged after write cycles.
- RD and WR are never low simultaneously. ALE is never high while a strobe is low.
- Reset mid-cycle: strobes release immediately and asynchronously; no rsp_valid is issued for the aborted cycle.
- READY is ignored outside T3/TW.

Decomposition:
- bus_pkg:
  - bus_state_t one-hot enum (IDLE, T1, T2, T3, TW, T4).
  - ADDR_W/DATA_W defaults.
  - bus_req_t struct (write, iom, addr, wdata).
  - RDATA_ERR constant (all-ones).
- One sub-module, bus_wait_timer:
  - Inputs: clear and count enable.
  - Output: expired flag at WAIT_MAX.
  - Same clock and active-low async reset.

Test Plan:
- Reset, then read req addr=20'h00010, READY=1, device preloaded 8'h5A -> ALE high cycle 1, RD low cycles 2-3, rsp_valid at cycle 4, rsp_rdata=8'h5A, rsp_err=0.
- Write req addr=20'h00020, wdata=8'hC3, READY=1 -> WR low cycles 2-3, WrData=8'hC3 in T2..T4, RD stays 1, rsp_valid at cycle 4, rsp_err=0.
- Read with READY low for 3 cycles after T3 -> 3 TW cycles, RD low throughout, rsp_valid at cycle 7 with device data.
- READY held low, WAIT_MAX=15 -> 15 TW cycles, then T4, rsp_valid=1, rsp_err=1, rsp_rdata=8'hFF, RD released.
- req_valid held high for 3 reads -> accepts in IDLE then each T4, ALE pulses every 4 cycles, 3 rsp_valid pulses, no IDLE between cycles.
- Assert RESET low during T3 of a read -> RD=1 and ALE=0 immediately, no rsp_valid; after release a fresh read completes normally.
